// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and helpers for the I/O stream blocks
package io_pkg;

    // 100 ms at 48 MHz, the default LED stretch time
    localparam int CLK48_100MS = 4800000;

    // Channel assignment at the top level
    localparam int CH_USB = 0;
    localparam int CH_KB  = 1;

    // Tag width: clog2 of the channel count, never narrower than one bit
    function automatic int tag_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/activity_stretch.sv
// rtl/activity_stretch.sv - retriggerable activity stretcher for one LED
module activity_stretch
    import io_pkg::*;
#(
    parameter int HOLD    = CLK48_100MS,
    parameter int ACT_INV = 1
) (
    input  logic clk48,
    input  logic rst,
    input  logic trig,
    output logic act
);

    // A zero HOLD still needs a one-bit counter; it simply never leaves zero
    localparam int CW = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);

    logic [CW-1:0] count;

    // Reload on every trigger so a busy channel keeps the LED lit
    always_ff @(posedge clk48) begin
        if (rst) begin
            count <= '0;
        end else if (trig) begin
            count <= CW'(HOLD);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    // Forced inactive during reset so the LED never shows a stale count
    assign act = ((count != '0) && !rst) ^ (ACT_INV != 0);

endmodule

// File: rtl/stream_merge.sv
// rtl/stream_merge.sv - round-robin N-channel byte-stream concentrator with FIFO
module stream_merge
    import io_pkg::*;
#(
    parameter int  CHANNELS = 2,
    parameter int  WIDTH    = 8,
    parameter int  DEPTH    = 4,
    parameter int  HOLD     = CLK48_100MS,
    parameter int  ACT_INV  = 1,
    localparam int TAG_W    = tag_width(CHANNELS)
) (
    input  logic                      clk48,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    fill,
    output logic [CHANNELS-1:0]       act
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t            mem [DEPTH];
    beat_t            head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fill_q;
    logic [TAG_W-1:0] ptr;
    logic [TAG_W-1:0] grant;
    logic             found;
    logic             full;
    logic             push;
    logic             pop;

    assign full = (fill_q == (AW + 1)'(DEPTH));

    // Round-robin search from ptr upward with wrap; first valid channel wins
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!found && in_valid[(int'(ptr) + k) % CHANNELS]) begin
                found = 1'b1;
                grant = TAG_W'((int'(ptr) + k) % CHANNELS);
            end
        end
    end

    // Only the granted lane sees ready, and only while there is room
    always_comb begin
        in_ready = '0;
        if (found && !full && !rst) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign push      = found && !full && !rst;
    assign out_valid = (fill_q != '0) && !rst;
    assign pop       = out_valid && out_ready;
    assign fill      = rst ? '0 : fill_q;
    assign head      = mem[rd_ptr];
    assign out_data  = head.data;
    assign out_tag   = head.tag;

    // FIFO storage; only the granted (valid) lane is ever captured
    always_ff @(posedge clk48) begin
        if (push) begin
            mem[wr_ptr] <= '{tag: grant, data: in_data[int'(grant)*WIDTH +: WIDTH]};
        end
    end

    // Pointers, occupancy and arbitration priority
    always_ff @(posedge clk48) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
            ptr    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                ptr    <= TAG_W'((int'(grant) + 1) % CHANNELS);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fill_q <= fill_q + (AW + 1)'(1);
            end else if (!push && pop) begin
                fill_q <= fill_q - (AW + 1)'(1);
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_act
        activity_stretch #(
            .HOLD    (HOLD),
            .ACT_INV (ACT_INV)
        ) u_act (
            .clk48 (clk48),
            .rst   (rst),
            .trig  (in_valid[i] & in_ready[i]),
            .act   (act[i])
        );
    end

endmodule

// File: tb/tb_stream_merge.sv
// tb/tb_stream_merge.sv - randomized self-checking bench for stream_merge
module tb_stream_merge;
    import io_pkg::*;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int H  = 10;

    logic            clk48 = 1'b0;
    logic            rst;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [W-1:0]    out_data;
    logic [0:0]      out_tag;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      fill;
    logic [CH-1:0]   act;

    always #5 clk48 = ~clk48;

    stream_merge #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .DEPTH    (D),
        .HOLD     (H),
        .ACT_INV  (1)
    ) dut (
        .clk48     (clk48),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill      (fill),
        .act       (act)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: queue of {tag,data}, rotating priority, time of last accept
    logic [15:0]  q[$];
    int           ptr;
    int           last_acc [CH];
    int           cyc;
    bit           pend [CH];
    logic [W-1:0] pdata [CH];
    logic [W-1:0] base [CH];
    int           seq [CH];
    bit           rand_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // pv: percent chance of a new beat on an idle channel; negative withdraws a pending beat
    task automatic run(input int n, input int pv0, input int pv1, input int pr, input bit r);
        int pv [CH];
        int acc;
        bit do_pop;
        logic [CH-1:0] exp_ready;
        logic [CH-1:0] exp_act;
        pv[0] = pv0;
        pv[1] = pv1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk48);
            for (int i = 0; i < CH; i++) begin
                if (pv[i] < 0) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && int'($urandom_range(99)) < pv[i]) begin
                    pend[i]  = 1'b1;
                    pdata[i] = rand_data ? W'($urandom) : W'(base[i] + W'(seq[i]));
                    seq[i]++;
                end
            end
            for (int i = 0; i < CH; i++) begin
                in_valid[i]         = pend[i];
                in_data[i*W +: W]   = pend[i] ? pdata[i] : W'($urandom);
            end
            out_ready = (int'($urandom_range(99)) < pr);
            rst       = r;
            #1;
            acc = -1;
            for (int k = 0; k < CH; k++) begin
                if (acc < 0 && pend[(ptr + k) % CH]) acc = (ptr + k) % CH;
            end
            if (r || q.size() >= D) acc = -1;
            exp_ready = '0;
            if (acc >= 0) exp_ready[acc] = 1'b1;
            for (int i = 0; i < CH; i++) begin
                exp_act[i] = !(!r && (cyc - last_acc[i]) >= 0 && (cyc - last_acc[i]) < H);
            end
            do_pop = !r && out_ready && q.size() > 0;
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("out_valid", 32'(out_valid), 32'(!r && q.size() > 0));
            check("fill", 32'(fill), r ? 32'd0 : 32'(q.size()));
            check("act", 32'(act), 32'(exp_act));
            if (!r && q.size() > 0) begin
                check("out_data", 32'(out_data), 32'(q[0][7:0]));
                check("out_tag", 32'(out_tag), 32'(q[0][15:8]));
            end
            @(posedge clk48);
            #1;
            cyc++;
            if (r) begin
                q.delete();
                ptr = 0;
                for (int i = 0; i < CH; i++) last_acc[i] = -1000;
            end else begin
                if (do_pop) void'(q.pop_front());
                if (acc >= 0) begin
                    q.push_back({8'(acc), pdata[acc]});
                    pend[acc]     = 1'b0;
                    ptr           = (acc + 1) % CH;
                    last_acc[acc] = cyc;
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        ptr       = 0;
        cyc       = 0;
        rand_data = 1'b0;
        for (int i = 0; i < CH; i++) begin
            last_acc[i] = -1000;
            pend[i]     = 1'b0;
            seq[i]      = 0;
        end
        base[CH_USB] = 8'hA0;
        base[CH_KB]  = 8'hB0;

        // reset with both channels requesting, then alternating service
        run(3, 100, 100, 0, 1'b1);
        run(12, 100, 100, 100, 1'b0);
        run(4, -1, -1, 100, 1'b0);

        // fill to the full boundary from channel 1, pop while full, then refill
        base[CH_KB] = 8'h11;
        seq[CH_KB]  = 0;
        run(5, -1, 100, 0, 1'b0);
        run(1, -1, 0, 100, 1'b0);
        run(2, -1, 0, 0, 1'b0);
        run(6, -1, -1, 100, 1'b0);

        // steady occupancy of two with one in and one out per cycle
        base[CH_USB] = 8'h40;
        seq[CH_USB]  = 0;
        run(2, 100, -1, 0, 1'b0);
        run(10, 100, -1, 100, 1'b0);
        run(4, -1, -1, 100, 1'b0);

        // single beat stretch, then a retrigger five cycles later
        run(1, 100, -1, 100, 1'b0);
        run(4, 0, -1, 100, 1'b0);
        run(1, 100, -1, 100, 1'b0);
        run(16, 0, -1, 100, 1'b0);

        // reset pulse with data queued and LEDs lit
        run(3, 100, -1, 0, 1'b0);
        run(1, -1, -1, 0, 1'b1);
        run(8, 100, 100, 100, 1'b0);

        // random traffic with occasional resets
        rand_data = 1'b1;
        for (int b = 0; b < 20; b++) begin
            run(30, int'($urandom_range(100)), int'($urandom_range(100)),
                int'($urandom_range(100)), 1'b0);
            run(1, 50, 50, 50, ($urandom_range(3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
